// File: rtl/instr_mem_pkg.sv
// Shared widths for the instruction-memory byte filler and the word serializer,
// so both ends of the byte stream agree on one definition.
package instr_mem_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int NBYTES = WORD_W / BYTE_W;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } ser_state_t;

endpackage

// File: rtl/word_serializer.sv
// Drains WORD_W-bit words into a BYTE_W-bit valid/ready stream, least-significant
// byte first, sustaining one byte per cycle with no bubble between words.
module word_serializer
  import instr_mem_pkg::ser_state_t;
  import instr_mem_pkg::S_IDLE;
  import instr_mem_pkg::S_SEND;
#(
  parameter int WORD_W = instr_mem_pkg::WORD_W,
  parameter int BYTE_W = instr_mem_pkg::BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              byte_last,
  output logic              word_done
);

  localparam int NBYTES = WORD_W / BYTE_W;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  if ((WORD_W % BYTE_W) != 0) begin : g_bad_width
    $error("word_serializer: WORD_W must be a multiple of BYTE_W");
  end

  ser_state_t        state_q, state_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              done_q;

  logic sending;
  logic byte_xfer;
  logic last_xfer;
  logic word_xfer;

  assign sending    = (state_q == S_SEND);
  assign byte_valid = sending;
  assign byte_out   = sending ? shift_q[BYTE_W-1:0] : '0;
  assign byte_last  = sending && (idx_q == LAST_IDX);

  assign byte_xfer = byte_valid && byte_ready;
  assign last_xfer = byte_xfer && byte_last;

  // byte_ready feeds word_ready combinationally so the next word loads on the
  // same edge that retires the final byte of the current one.
  assign word_ready = !sending || (byte_last && byte_ready);
  assign word_xfer  = word_valid && word_ready;

  assign word_done = done_q;

  always_comb begin
    // NOTE: every next-state value gets its hold default first, so no path
    // through the branches below can leave one unassigned and infer a latch.
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;

    if (word_xfer) begin
      state_d = S_SEND;
      shift_d = word_in;
      idx_d   = '0;
    end else if (last_xfer) begin
      state_d = S_IDLE;
    end else if (byte_xfer) begin
      shift_d = shift_q >> BYTE_W;
      idx_d   = idx_q + IDX_W'(1);
    end
  end

  // NOTE: registers update with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order inside the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      done_q  <= last_xfer;
    end
  end

endmodule
